seg7_countdown_ctrl: RTL and testbench

Sequencing controller for the 4-bit count / 7-segment display datapath in a TinyTapeout user slot. It loads a 4-bit start value from the input pins, decrements it at a prescaled rate under start/stop control, and drives the decoded digit onto the segment outputs. It raises a done flag when the count reaches zero. The block occupies the full 8-in / 8-out user-module pin budget.

---
 rtl/seg7_countdown_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_seg7_countdown_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_countdown_ctrl.sv
// 4-bit countdown sequencer driving a 7-segment digit in a TinyTapeout 8-in/8-out slot.
// Optional build macro SEG7_COUNTDOWN_BLINK_EN makes the zero digit blink while done.
`timescale 1ns/1ps
module seg7_countdown_ctrl #(
  parameter int PRESCALE = 1000
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int              PW         = $clog2(PRESCALE);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
  localparam logic [6:0]      SEG_ZERO   = 7'h3F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic          w_clk;
  logic          w_rst_n;
  logic [3:0]    w_load;

  logic          r_start_p0;
  logic          r_start_p1;
  logic          r_stop_p0;
  logic          r_stop_p1;
  logic          w_start_ev;
  logic          w_stop_ev;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_count;
  logic [3:0]    w_count_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic          w_presc_wrap;
  logic          w_load_go;
`ifdef SEG7_COUNTDOWN_BLINK_EN
  logic          r_blink;
  logic          w_blink_nxt;
`endif

  logic [3:0]    w_disp;
  logic [6:0]    w_seg;
  logic [7:0]    r_out;

  assign w_clk   = io_in[0];
  assign w_rst_n = io_in[1];
  assign w_load  = io_in[7:4];

  // Stage p0/p1: pin sample and previous sample for rising-edge detection
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_start_p0 <= 1'b0;
      r_start_p1 <= 1'b0;
      r_stop_p0  <= 1'b0;
      r_stop_p1  <= 1'b0;
    end else begin
      r_start_p0 <= io_in[2];
      r_start_p1 <= r_start_p0;
      r_stop_p0  <= io_in[3];
      r_stop_p1  <= r_stop_p0;
    end
  end

  assign w_start_ev   = r_start_p0 & ~r_start_p1;
  assign w_stop_ev    = r_stop_p0 & ~r_stop_p1;
  assign w_presc_wrap = (r_presc == PRESC_LAST);

  // Stage: sequencing state, count and prescaler
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_count <= 4'd0;
      r_presc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_presc <= w_presc_nxt;
    end
  end

`ifdef SEG7_COUNTDOWN_BLINK_EN
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) r_blink <= 1'b0;
    else          r_blink <= w_blink_nxt;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_presc_nxt = r_presc;
    w_load_go   = 1'b0;
`ifdef SEG7_COUNTDOWN_BLINK_EN
    w_blink_nxt = 1'b0;
`endif
    // A stop edge always takes priority over a start edge in the same cycle.
    unique case (r_state)
      ST_IDLE: begin
        if (!w_stop_ev && w_start_ev) w_load_go = 1'b1;
      end
      ST_RUN: begin
        if (w_stop_ev) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_presc_wrap) begin
          w_presc_nxt = '0;
          if (r_count != 4'd0) w_count_nxt = r_count - 4'd1;
          if (r_count <= 4'd1) w_state_nxt = ST_DONE;
        end else begin
          w_presc_nxt = r_presc + PRESC_ONE;
        end
      end
      ST_PAUSE: begin
        if (w_stop_ev)       w_state_nxt = ST_IDLE;
        else if (w_start_ev) w_state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (w_stop_ev) begin
          w_state_nxt = ST_IDLE;
        end else if (w_start_ev) begin
          w_load_go = 1'b1;
        end else begin
`ifdef SEG7_COUNTDOWN_BLINK_EN
          if (w_presc_wrap) begin
            w_presc_nxt = '0;
            w_blink_nxt = ~r_blink;
          end else begin
            w_presc_nxt = r_presc + PRESC_ONE;
            w_blink_nxt = r_blink;
          end
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_load_go) begin
      w_count_nxt = w_load;
      w_presc_nxt = '0;
      w_state_nxt = (w_load == 4'd0) ? ST_DONE : ST_RUN;
    end
  end

  // Load value bypasses the sample stage so IDLE tracks the pins directly.
  always_comb begin
    w_disp = (r_state == ST_IDLE) ? w_load : r_count;
    w_seg  = seg_decode(w_disp);
    if (r_state == ST_DONE) begin
      w_seg = SEG_ZERO;
`ifdef SEG7_COUNTDOWN_BLINK_EN
      if (r_blink) w_seg = 7'h00;
`endif
    end
  end

  // Stage: registered pin outputs
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) r_out <= 8'h00;
    else          r_out <= {(r_state == ST_DONE), w_seg};
  end

  assign io_out = r_out;

endmodule

// File: tb/tb_seg7_countdown_ctrl.sv
// Randomized scoreboard bench for seg7_countdown_ctrl; the reference model tracks
// elapsed run time rather than a prescaler, and the monitor checks io_out every cycle.
`timescale 1ns/1ps
module tb_seg7_countdown_ctrl;

  localparam int P = 4;
`ifdef SEG7_COUNTDOWN_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic [3:0] load  = 4'd0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {load, stop, start, rst_n, clk};

  seg7_countdown_ctrl #(.PRESCALE(P)) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t  sb_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  string cur_tag  = "reset";

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: count is derived from cycles spent running
  int m_mode     = M_IDLE;
  int m_loadv    = 0;
  int m_elapsed  = 0;
  int m_done_cyc = 0;
  bit m_ss = 1'b0, m_sp = 1'b0, m_ts = 1'b0, m_tp = 1'b0;

  function automatic logic [7:0] m_out(input logic [3:0] live);
    logic [7:0] o;
    int remaining;
    case (m_mode)
      M_IDLE: o = {1'b0, seg_tab[live]};
      M_DONE: begin
        if (BLINK && (((m_done_cyc / P) % 2) == 1)) o = 8'h80;
        else                                         o = 8'hBF;
      end
      default: begin
        remaining = m_loadv - (m_elapsed / P);
        o = {1'b0, seg_tab[remaining[3:0]]};
      end
    endcase
    return o;
  endfunction

  task automatic m_begin_load(input logic [3:0] v);
    m_loadv    = int'(v);
    m_elapsed  = 0;
    m_done_cyc = 0;
    m_mode     = (v == 4'd0) ? M_DONE : M_RUN;
  endtask

  task automatic step(input bit r, input bit s, input bit t, input logic [3:0] l);
    exp_t e;
    bit ev_s, ev_t;
    rst_n = r;
    start = s;
    stop  = t;
    load  = l;
    if (!r) begin
      e.exp      = 8'h00;
      m_mode     = M_IDLE;
      m_loadv    = 0;
      m_elapsed  = 0;
      m_done_cyc = 0;
      m_ss = 1'b0; m_sp = 1'b0; m_ts = 1'b0; m_tp = 1'b0;
    end else begin
      e.exp = m_out(l);
      ev_s  = m_ss & ~m_sp;
      ev_t  = m_ts & ~m_tp;
      case (m_mode)
        M_IDLE: if (!ev_t && ev_s) m_begin_load(l);
        M_RUN: begin
          if (ev_t) m_mode = M_PAUSE;
          else begin
            m_elapsed++;
            if (m_elapsed >= m_loadv * P) begin
              m_mode     = M_DONE;
              m_done_cyc = 0;
            end
          end
        end
        M_PAUSE: begin
          if (ev_t)      m_mode = M_IDLE;
          else if (ev_s) m_mode = M_RUN;
        end
        default: begin
          if (ev_t)      m_mode = M_IDLE;
          else if (ev_s) m_begin_load(l);
          else           m_done_cyc++;
        end
      endcase
      m_sp = m_ss; m_ss = s;
      m_tp = m_ts; m_ts = t;
    end
    e.tag = cur_tag;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [3:0] l);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, l);
  endtask

  task automatic pulse_start(input logic [3:0] l);
    step(1'b1, 1'b1, 1'b0, l);
    step(1'b1, 1'b0, 1'b0, l);
  endtask

  task automatic pulse_stop(input logic [3:0] l);
    step(1'b1, 1'b0, 1'b1, l);
    step(1'b1, 1'b0, 1'b0, l);
  endtask

  // Monitor: io_out is presented every cycle, compared just after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (io_out === e.exp) n_pass++;
        else $display("FAIL %s: io_out=0x%02h expected 0x%02h at %0t", e.tag, io_out, e.exp, $time);
      end
    end
  end

  initial begin
    bit rs, rt, rr;
    logic [3:0] rl;

    cur_tag = "reset";
    step(1'b0, 1'b0, 1'b0, 4'd5);
    step(1'b0, 1'b0, 1'b0, 4'd5);
    idle(3, 4'd5);
    idle(2, 4'd9);

    cur_tag = "countdown";
    pulse_start(4'd3);
    idle(20, 4'd3);

    cur_tag = "pause_resume";
    pulse_start(4'd3);
    idle(8, 4'd3);
    pulse_stop(4'd3);
    idle(20, 4'd3);
    pulse_start(4'd3);
    idle(20, 4'd3);

    cur_tag = "load_zero";
    pulse_stop(4'd0);
    pulse_start(4'd0);
    idle(4, 4'd0);

    cur_tag = "start_stop_same_cycle";
    pulse_start(4'd9);
    idle(5, 4'd9);
    step(1'b1, 1'b1, 1'b1, 4'd9);
    idle(6, 4'd9);
    step(1'b1, 1'b1, 1'b1, 4'd9);
    idle(4, 4'd6);

    cur_tag = "mid_run_reset";
    pulse_start(4'd3);
    idle(7, 4'd3);
    step(1'b0, 1'b0, 1'b0, 4'd3);
    idle(4, 4'd7);

    cur_tag = "done_display";
    pulse_start(4'd1);
    idle(30, 4'd1);

    cur_tag = "random";
    rs = 1'b0; rt = 1'b0; rl = 4'd4;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0)  rs = ~rs;
      if ($urandom_range(0, 24) == 0) rt = ~rt;
      if ($urandom_range(0, 19) == 0) rl = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 299) == 0);
      step(~rr, rs, rt, rl);
    end

    cur_tag = "drain";
    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: pending=%0d expected 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
